// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage feeding decode. Owns the fetch PC, absorbs the
//   one-cycle latency of the synchronous instruction memory, freezes the
//   presented instruction while decode stalls, and squashes the wrong-path
//   slot on a redirect. Any slot without a live instruction carries NOP so
//   the decoders downstream never see stale memory data.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   stall        in   decode cannot accept; hold PC and presented instruction
//   redirect     in   taken branch/jump; squash this slot, fetch redirect_pc
//   redirect_pc  in   redirect target (bits [1:0] ignored)
//   imem_en      out  IMEM read enable
//   imem_addr    out  IMEM word address
//   imem_rdata   in   IMEM data, one cycle after an enabled read
//   inst_d       out  instruction presented to decode
//   pc_d         out  PC of inst_d
//   valid_d      out  inst_d is architecturally live
//   fetch_count  out  number of instructions accepted by decode
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_2000,
    parameter int          IMEM_AW  = 14,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        inst_d,
    output logic [31:0]        pc_d,
    output logic               valid_d,
    output logic [31:0]        fetch_count
);

    logic [31:0] pc_f_q,        pc_f_d;
    logic        pend_v_q,      pend_v_d;
    logic [31:0] pend_pc_q,     pend_pc_d;
    logic        hold_v_q,      hold_v_d;
    logic [31:0] hold_inst_q,   hold_inst_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic [31:0] redir_pc_al;
    logic        accept;

    assign redir_pc_al = redirect_pc & ~32'h3;

    // Issue side: a redirect target goes to memory in the same cycle so the
    // penalty is a single squashed slot.
    assign imem_en   = (rst_n & ~stall) | redirect;
    assign imem_addr = redirect ? redir_pc_al[IMEM_AW+1:2] : pc_f_q[IMEM_AW+1:2];

    // Presentation mux. The held copy must win over live memory data because
    // the memory output is meaningless once reads stop during a stall.
    always_comb begin
        inst_d  = NOP;
        valid_d = 1'b0;
        if (redirect) begin
            inst_d  = NOP;
            valid_d = 1'b0;
        end else if (hold_v_q) begin
            inst_d  = hold_inst_q;
            valid_d = 1'b1;
        end else if (pend_v_q) begin
            inst_d  = imem_rdata;
            valid_d = 1'b1;
        end
    end

    assign pc_d        = pend_pc_q;
    assign fetch_count = fetch_count_q;
    assign accept      = valid_d & ~stall & ~redirect;

    always_comb begin
        pc_f_d        = pc_f_q;
        pend_v_d      = pend_v_q;
        pend_pc_d     = pend_pc_q;
        hold_v_d      = hold_v_q;
        hold_inst_d   = hold_inst_q;
        fetch_count_d = fetch_count_q + {31'd0, accept};

        if (redirect) begin
            pc_f_d    = redir_pc_al + 32'd4;
            pend_pc_d = redir_pc_al;
            pend_v_d  = 1'b1;
            hold_v_d  = 1'b0;
        end else if (stall) begin
            // Capture only on the first stall cycle: that is the single cycle
            // in which imem_rdata still carries the pending instruction.
            if (pend_v_q && !hold_v_q) begin
                hold_inst_d = imem_rdata;
                hold_v_d    = 1'b1;
            end
        end else begin
            // The held instruction (if any) is consumed this cycle, so the
            // next PC is issued immediately without a duplicate slot.
            pend_pc_d = pc_f_q;
            pend_v_d  = 1'b1;
            pc_f_d    = pc_f_q + 32'd4;
            hold_v_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_f_q        <= RESET_PC;
            pend_v_q      <= 1'b0;
            pend_pc_q     <= RESET_PC;
            hold_v_q      <= 1'b0;
            hold_inst_q   <= NOP;
            fetch_count_q <= 32'd0;
        end else begin
            pc_f_q        <= pc_f_d;
            pend_v_q      <= pend_v_d;
            pend_pc_q     <= pend_pc_d;
            hold_v_q      <= hold_v_d;
            hold_inst_q   <= hold_inst_d;
            fetch_count_q <= fetch_count_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_2000;
    localparam int          IMEM_AW  = 14;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               stall;
    logic               redirect;
    logic [31:0]        redirect_pc;
    logic               imem_en;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic [31:0]        inst_d;
    logic [31:0]        pc_d;
    logic               valid_d;
    logic [31:0]        fetch_count;

    int checks = 0;
    int errors = 0;

    fetch_stage #(
        .RESET_PC (RESET_PC),
        .IMEM_AW  (IMEM_AW),
        .NOP      (NOP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .inst_d      (inst_d),
        .pc_d        (pc_d),
        .valid_d     (valid_d),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    // Memory contents: the word at a byte address is the address itself
    // (within the 64 KiB window the word address can reach).
    function automatic logic [31:0] mem_word(input logic [IMEM_AW-1:0] w);
        return {16'h0000, w, 2'b00};
    endfunction

    // Synchronous IMEM; when no read is enabled its output is garbage.
    initial imem_rdata = 32'h0;
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem_word(imem_addr);
        else         imem_rdata <= $urandom;
    end

    // Reference model in terms of the instruction stream seen by decode:
    // the slot currently presented and the next sequential PC to fetch.
    logic [31:0] m_next;
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_count;

    function automatic logic [31:0] inst_at(input logic [31:0] pc);
        return mem_word(pc[IMEM_AW+1:2]);
    endfunction

    task automatic model_reset();
        m_next  = RESET_PC;
        m_valid = 1'b0;
        m_pc    = RESET_PC;
        m_count = 32'd0;
    endtask

    task automatic model_edge();
        logic [31:0] tgt;
        tgt = {redirect_pc[31:2], 2'b00};
        if (!rst_n) begin
            model_reset();
        end else if (redirect) begin
            m_valid = 1'b1;
            m_pc    = tgt;
            m_next  = tgt + 32'd4;
        end else if (!stall) begin
            if (m_valid) m_count = m_count + 32'd1;
            m_valid = 1'b1;
            m_pc    = m_next;
            m_next  = m_next + 32'd4;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_addr;
        e_valid = m_valid & ~redirect;
        e_inst  = e_valid ? inst_at(m_pc) : NOP;
        e_addr  = redirect ? {redirect_pc[31:2], 2'b00} : m_next;
        chk("valid_d", {31'd0, valid_d}, {31'd0, e_valid});
        chk("inst_d", inst_d, e_inst);
        chk("pc_d", pc_d, m_pc);
        chk("fetch_count", fetch_count, m_count);
        chk("imem_en", {31'd0, imem_en}, {31'd0, (rst_n & ~stall) | redirect});
        if (imem_en)
            chk("imem_addr", {18'd0, imem_addr}, {18'd0, e_addr[IMEM_AW+1:2]});
    endtask

    // One clock cycle: commit the previous cycle's inputs into the model at
    // the edge, then drive this cycle's inputs and check outputs mid-cycle.
    task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rp);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        rst_n       = r;
        stall       = s;
        redirect    = rd;
        redirect_pc = rp;
        #1;
        check_model();
    endtask

    logic [31:0] frozen_inst;
    logic [31:0] frozen_pc;

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        model_reset();

        // Reset held low; outputs must already be idle.
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rst_inst", inst_d, NOP);
        chk("rst_valid", {31'd0, valid_d}, 32'd0);
        chk("rst_pc", pc_d, RESET_PC);

        // Release: cycle 1 issues 0x2000, cycle 2 shows it, cycle 3 shows 0x2004.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("c1_en", {31'd0, imem_en}, 32'd1);
        chk("c1_addr", {18'd0, imem_addr}, 32'h800);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("c2_inst", inst_d, 32'h2000);
        chk("c2_valid", {31'd0, valid_d}, 32'd1);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("c3_pc", pc_d, 32'h2004);

        // Stall three cycles on 0x2008 with garbage coming back from memory.
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("c4_cnt", fetch_count, 32'd2);
        chk("stall_pc", pc_d, 32'h2008);
        frozen_inst = inst_d;
        frozen_pc   = pc_d;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("stall_frz_inst", inst_d, frozen_inst);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("stall_frz_inst2", inst_d, frozen_inst);
        chk("stall_frz_pc", pc_d, frozen_pc);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("release_inst", inst_d, 32'h2008);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("after_release", pc_d, 32'h200C);
        chk("release_cnt", fetch_count, 32'd3);

        // Redirect to an unaligned target at pc 0x2010.
        step(1'b1, 1'b0, 1'b1, 32'h0000_3002);
        chk("redir_inst", inst_d, NOP);
        chk("redir_addr", {18'd0, imem_addr}, 32'h0C00);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("redir_tgt", pc_d, 32'h3000);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("redir_next", pc_d, 32'h3004);

        // Stall, then redirect together with stall: redirect wins.
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_4000);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("rs_tgt_inst", inst_d, 32'h4000);
        chk("rs_tgt_pc", pc_d, 32'h4000);

        // Wrap of the 32-bit PC.
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("wrap_hi", pc_d, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("wrap_lo", pc_d, 32'h0000_0000);

        // Back-to-back redirects: later one wins.
        step(1'b1, 1'b0, 1'b1, 32'h0000_5000);
        step(1'b1, 1'b0, 1'b1, 32'h0000_6004);
        chk("b2b_valid", {31'd0, valid_d}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("b2b_pc", pc_d, 32'h6004);

        // Reset for one cycle in the middle of a stall.
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("mid_rst_valid", {31'd0, valid_d}, 32'd0);
        chk("mid_rst_cnt", fetch_count, 32'd0);
        chk("mid_rst_addr", {18'd0, imem_addr}, 32'h800);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("mid_rst_inst", inst_d, 32'h2000);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic        r, s, rd;
            logic [31:0] rp;
            r  = ($urandom_range(0, 39) != 0);
            s  = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 7) == 0);
            rp = $urandom;
            if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0 | (rp & 32'hF);
            step(r, s, rd, rp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
